// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM encoding, the default test address and the byte merge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEF_TEST_ADDR = 32'h0000_0100;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready bundle between the M stage and the responder.
// The master drives requests and consumes responses.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Byte-enabled word RAM with synchronous clear and combinational read.
// One index serves both the read and the write path.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    assign rdata_o = mem_q[idx_i];

    // Clear every word on reset, otherwise merge enabled bytes into one word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[idx_i] <= byte_merge(mem_q[idx_i], wdata_i, be_i);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder for the core's load/store port.
// Accepts one request, waits, commits, then holds the response until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] TEST_ADDR   = DEF_TEST_ADDR
) (
    input  logic            CLK,
    input  logic            RST,
    dmem_responder_if.slave bus,
    output logic [31:0]     test
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CW-1:0] CNT_INIT =
        CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic [31:0]   test_q;
    logic [31:0]   test_d;
    logic [31:0]   rdata_d;

    logic          t_we;
    logic [31:0]   t_addr;
    logic [31:0]   t_wdata;
    logic [3:0]    t_be;
    logic          t_is_test;
    logic          t_err;
    logic          accept;
    logic          commit;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    assign bus.req_ready = (state_q == IDLE) && !RST;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign test          = test_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Select the live bus in IDLE (zero-wait commit) or the latched request.
    always_comb begin
        t_we    = we_q;
        t_addr  = addr_q;
        t_wdata = wdata_q;
        t_be    = be_q;
        if (state_q == IDLE) begin
            t_we    = bus.req_we;
            t_addr  = bus.req_addr;
            t_wdata = bus.req_wdata;
            t_be    = bus.req_be;
        end
    end

    // Decode, commit strobe and next values of test register and read data.
    always_comb begin
        t_is_test = (t_addr == TEST_ADDR);
        t_err     = (t_addr[1:0] != 2'b00)
                 || ((t_addr[31:2] >= 30'(DEPTH)) && !t_is_test);
        commit    = (ZERO_WAIT && (state_q == IDLE) && accept)
                 || ((state_q == WAIT) && (cnt_q == '0));
        ram_we    = commit && t_we && !t_err && !t_is_test;
        test_d    = test_q;
        if (commit && t_we && !t_err && t_is_test) begin
            test_d = byte_merge(test_q, t_wdata, t_be);
        end
        rdata_d = '0;
        if (!t_we && !t_err) begin
            rdata_d = t_is_test ? test_q : ram_rdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (ram_we),
        .idx_i   (t_addr[AW+1:2]),
        .wdata_i (t_wdata),
        .be_i    (t_be),
        .rdata_o (ram_rdata)
    );

    // Transaction FSM: latch on accept, count waits, commit, hold response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            test_q      <= '0;
        end else begin
            test_q <= test_d;
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata_d;
                rsp_err_q   <= t_err;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        cnt_q   <= CNT_INIT;
                        state_q <= ZERO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= RESP;
                    else cnt_q <= cnt_q - 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
